// File: rtl/cpu_sequencer.sv
// Hardwired control sequencer: fetch/decode/execute FSM driving a 24-bit control word.
// Optional macro SEQ_MEM_STALL_EN: READ/WRITE states hold while mem_ready=0.
module cpu_sequencer #(
  parameter int OPCODE_W   = 8,
  parameter int ADDR_BYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                z_flag,
  input  logic                mem_ready,
  output logic [23:0]         ctrl_word,
  output logic [3:0]          state,
  output logic                instr_done,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_F1 = 4'd0, S_F2 = 4'd1, S_F3 = 4'd2, S_EX = 4'd3,
    S_OPRD = 4'd4, S_OPLD = 4'd5, S_OPRD_LAST = 4'd6, S_ADDR = 4'd7,
    S_JMP = 4'd8, S_IDLE = 4'd9, S_LD1 = 4'd10, S_LD2 = 4'd11,
    S_ST1 = 4'd12, S_ST2 = 4'd13
  } state_t;

  localparam logic [23:0] RLOAD  = 24'h080000, TRLOAD = 24'h040000;
  localparam logic [23:0] ARLOAD = 24'h020000, ARINC  = 24'h010000;
  localparam logic [23:0] PCLOAD = 24'h008000, PCINC  = 24'h004000;
  localparam logic [23:0] DRLOAD = 24'h002000, ACLOAD = 24'h001000;
  localparam logic [23:0] IRLOAD = 24'h000800, ZLOAD  = 24'h000400;
  localparam logic [23:0] MEMBUS = 24'h000200, BUSMEM = 24'h000100;
  localparam logic [23:0] PCBUS  = 24'h000080, DRHBUS = 24'h000040;
  localparam logic [23:0] DRLBUS = 24'h000020, TRBUS  = 24'h000010;
  localparam logic [23:0] RBUS   = 24'h000008, ACBUS  = 24'h000004;
  localparam logic [23:0] READ   = 24'h000002, WRITE  = 24'h000001;
  localparam logic [23:0] LOAD_MASK = 24'h0FFC00;
  localparam logic [23:0] TR_SEL    = (ADDR_BYTES > 1) ? TRBUS : 24'h0;
  localparam logic [1:0]  CNT_LAST  = (ADDR_BYTES > 1) ? 2'(ADDR_BYTES - 2) : 2'd0;

  state_t      r_state, w_next;
  logic [1:0]  r_byte_cnt;
  logic [23:0] w_ctrl;
  logic [3:0]  w_op;
  logic        w_bad, w_is_mem, w_take, w_hold;

  assign w_op     = opcode[3:0];
  assign w_bad    = (opcode >> 4) != '0;
  assign w_is_mem = (w_op == 4'h1) || (w_op == 4'h2) || (w_op == 4'h5) ||
                    (w_op == 4'h6) || (w_op == 4'h7);
  assign w_take   = (w_op == 4'h5) || (w_op == 4'h6 && z_flag) || (w_op == 4'h7 && !z_flag);

  // Memory handshake: a state asserting READ or WRITE completes only in a
  // cycle where mem_ready=1; until then it repeats with load/inc bits masked.
`ifdef SEQ_MEM_STALL_EN
  assign w_hold = (w_ctrl[1] | w_ctrl[0]) & ~mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_F1;
      r_byte_cnt <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_OPLD) r_byte_cnt <= r_byte_cnt + 2'd1;
      else if (r_state == S_F1) r_byte_cnt <= 2'd0;
    end
  end

  always_comb begin
    w_next = S_F1;
    case (r_state)
      S_F1: w_next = S_F2;
      S_F2: w_next = S_F3;
      S_F3: begin
        if (w_bad || w_op == 4'h0) w_next = S_F1;
        else if (w_is_mem && ADDR_BYTES > 1) w_next = S_OPRD;
        else if (w_is_mem) w_next = S_OPRD_LAST;
        else w_next = S_EX;
      end
      S_OPRD: w_next = S_OPLD;
      S_OPLD: begin
        if (r_byte_cnt == CNT_LAST) w_next = S_OPRD_LAST;
        else w_next = S_OPRD;
      end
      S_OPRD_LAST: begin
        if (w_op == 4'h1 || w_op == 4'h2) w_next = S_ADDR;
        else if (w_take) w_next = S_JMP;
        else w_next = S_IDLE;
      end
      S_ADDR: begin
        if (w_op == 4'h1) w_next = S_LD1;
        else w_next = S_ST1;
      end
      S_LD1: w_next = S_LD2;
      S_ST1: w_next = S_ST2;
      default: w_next = S_F1;
    endcase
    if (w_hold) w_next = r_state;
  end

  always_comb begin
    w_ctrl     = 24'h0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_F1: w_ctrl = PCBUS | ARLOAD;
      S_F2: w_ctrl = READ | MEMBUS | DRLOAD | PCINC;
      S_F3: begin
        w_ctrl     = IRLOAD | PCBUS | ARLOAD;
        instr_done = w_bad || (w_op == 4'h0);
        illegal    = w_bad;
      end
      S_EX: begin
        instr_done = 1'b1;
        if (w_op == 4'h3) w_ctrl = ACBUS | RLOAD;
        else if (w_op == 4'h4) w_ctrl = RBUS | ACLOAD;
        else if (w_op[3]) begin
          // ALU ops 8..F map to ALU codes 1..8
          w_ctrl = ACLOAD | ZLOAD;
          w_ctrl[23:20] = {1'b0, w_op[2:0]} + 4'd1;
          if (w_op != 4'hA && w_op != 4'hB && w_op != 4'hF) w_ctrl = w_ctrl | RBUS;
        end
      end
      S_OPRD:      w_ctrl = READ | MEMBUS | DRLOAD | PCINC | ARINC;
      S_OPLD:      w_ctrl = TRLOAD;
      S_OPRD_LAST: w_ctrl = READ | MEMBUS | DRLOAD | PCINC;
      S_ADDR:      w_ctrl = DRHBUS | ARLOAD | TR_SEL;
      S_JMP: begin
        w_ctrl     = DRHBUS | PCLOAD | TR_SEL;
        instr_done = 1'b1;
      end
      S_IDLE: instr_done = 1'b1;
      S_LD1:  w_ctrl = READ | MEMBUS | DRLOAD;
      S_LD2: begin
        w_ctrl     = DRLBUS | ACLOAD;
        instr_done = 1'b1;
      end
      S_ST1: w_ctrl = ACBUS | DRLOAD;
      S_ST2: begin
        w_ctrl     = DRLBUS | BUSMEM | WRITE;
        instr_done = 1'b1;
      end
      default: w_ctrl = 24'h0;
    endcase
    if (w_hold) instr_done = 1'b0;
  end

  assign ctrl_word = w_hold ? (w_ctrl & ~LOAD_MASK) : w_ctrl;
  assign state     = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: drivers push per-cycle expectations, a monitor checks them.
module tb_cpu_sequencer;

  localparam logic [3:0] F1 = 4'd0, F2 = 4'd1, F3 = 4'd2, EX = 4'd3;
  localparam logic [3:0] OPRD = 4'd4, OPLD = 4'd5, OPRDL = 4'd6, ADDR = 4'd7;
  localparam logic [3:0] JMP = 4'd8, IDLE = 4'd9, LD1 = 4'd10, LD2 = 4'd11;
  localparam logic [3:0] ST1 = 4'd12, ST2 = 4'd13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  opcode = 8'h00;
  logic        z_flag = 1'b0;
  logic        mem_ready = 1'b1;
  logic [23:0] ctrl_word;
  logic [3:0]  state;
  logic        instr_done;
  logic        illegal;

  logic [29:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  cpu_sequencer #(.OPCODE_W(8), .ADDR_BYTES(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .z_flag(z_flag), .mem_ready(mem_ready),
    .ctrl_word(ctrl_word), .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, required finish", $time);
    $fatal(1);
  end

  // driver tasks
  task automatic push(input string nm, input logic [3:0] st, input logic [23:0] cw,
                      input logic d, input logic il);
    exp_q.push_back({st, cw, d, il});
    name_q.push_back(nm);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input string nm);
    push({nm, "_f1"}, F1, 24'h020080, 1'b0, 1'b0);
    push({nm, "_f2"}, F2, 24'h006202, 1'b0, 1'b0);
    push({nm, "_f3"}, F3, 24'h020880, 1'b0, 1'b0);
  endtask

  task automatic exec_instr(input string nm, input logic [7:0] op, input logic [23:0] cw);
    opcode = op;
    fetch(nm);
    push({nm, "_ex"}, EX, cw, 1'b1, 1'b0);
    cycles(4);
  endtask

  task automatic operand_fetch(input string nm);
    push({nm, "_oprd"}, OPRD, 24'h016202, 1'b0, 1'b0);
    push({nm, "_opld"}, OPLD, 24'h040000, 1'b0, 1'b0);
    push({nm, "_oprdl"}, OPRDL, 24'h006202, 1'b0, 1'b0);
  endtask

  task automatic jump_instr(input string nm, input logic [7:0] op, input logic z, input logic taken);
    opcode = op;
    z_flag = z;
    fetch(nm);
    operand_fetch(nm);
    if (taken) push({nm, "_jmp"}, JMP, 24'h008050, 1'b1, 1'b0);
    else push({nm, "_idle"}, IDLE, 24'h000000, 1'b1, 1'b0);
    cycles(7);
  endtask

  task automatic check_direct(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [29:0] exp;
    logic [29:0] act;
    string       nm;
    if (!rst && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {state, ctrl_word, instr_done, illegal};
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL %s: got st=%0d ctrl=%06h done=%b ill=%b, expected st=%0d ctrl=%06h done=%b ill=%b",
                 nm, act[29:26], act[25:2], act[1], act[0], exp[29:26], exp[25:2], exp[1], exp[0]);
      end
    end
  end

  initial begin
    cycles(2);
    check_direct("reset_state", 32'(state), 32'(F1));
    check_direct("reset_ctrl", 32'(ctrl_word), 32'h020080);
    check_direct("reset_done", 32'(instr_done), 32'h0);
    check_direct("reset_illegal", 32'(illegal), 32'h0);
    rst = 1'b0;

    exec_instr("add",  8'h08, 24'h101408);
    exec_instr("sub",  8'h09, 24'h201408);
    exec_instr("inac", 8'h0A, 24'h301400);
    exec_instr("clac", 8'h0B, 24'h401400);
    exec_instr("xor",  8'h0E, 24'h701408);
    exec_instr("not",  8'h0F, 24'h801400);
    exec_instr("mvac", 8'h03, 24'h080004);
    exec_instr("movr", 8'h04, 24'h001008);

    opcode = 8'h00;
    push("nop_f1", F1, 24'h020080, 1'b0, 1'b0);
    push("nop_f2", F2, 24'h006202, 1'b0, 1'b0);
    push("nop_f3", F3, 24'h020880, 1'b1, 1'b0);
    cycles(3);

    opcode = 8'h3F;
    push("ill_f1", F1, 24'h020080, 1'b0, 1'b0);
    push("ill_f2", F2, 24'h006202, 1'b0, 1'b0);
    push("ill_f3", F3, 24'h020880, 1'b1, 1'b1);
    cycles(3);

    opcode = 8'h01;
    fetch("ldac");
    operand_fetch("ldac");
    push("ldac_addr", ADDR, 24'h020050, 1'b0, 1'b0);
    push("ldac_ld1", LD1, 24'h002202, 1'b0, 1'b0);
    push("ldac_ld2", LD2, 24'h001020, 1'b1, 1'b0);
    cycles(9);

    opcode = 8'h02;
    fetch("stac");
    operand_fetch("stac");
    push("stac_addr", ADDR, 24'h020050, 1'b0, 1'b0);
    push("stac_st1", ST1, 24'h002004, 1'b0, 1'b0);
    push("stac_st2", ST2, 24'h000121, 1'b1, 1'b0);
    cycles(9);

    jump_instr("jump",    8'h05, 1'b0, 1'b1);
    jump_instr("jmpz_z0", 8'h06, 1'b0, 1'b0);
    jump_instr("jmpz_z1", 8'h06, 1'b1, 1'b1);
    jump_instr("jpnz_z0", 8'h07, 1'b0, 1'b1);
    jump_instr("jpnz_z1", 8'h07, 1'b1, 1'b0);
    z_flag = 1'b0;

    // abort LDAC in LD1 with an asynchronous reset
    opcode = 8'h01;
    fetch("abort");
    operand_fetch("abort");
    push("abort_addr", ADDR, 24'h020050, 1'b0, 1'b0);
    push("abort_ld1", LD1, 24'h002202, 1'b0, 1'b0);
    cycles(7);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_direct("abort_state", 32'(state), 32'(F1));
    check_direct("abort_ctrl", 32'(ctrl_word), 32'h020080);
    check_direct("abort_done", 32'(instr_done), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exec_instr("after_abort", 8'h0C, 24'h501408);

`ifdef SEQ_MEM_STALL_EN
    opcode = 8'h0D;
    mem_ready = 1'b0;
    push("stall_f1", F1, 24'h020080, 1'b0, 1'b0);
    push("stall_f2_h1", F2, 24'h000202, 1'b0, 1'b0);
    push("stall_f2_h2", F2, 24'h000202, 1'b0, 1'b0);
    push("stall_f2_h3", F2, 24'h000202, 1'b0, 1'b0);
    push("stall_f2", F2, 24'h006202, 1'b0, 1'b0);
    push("stall_f3", F3, 24'h020880, 1'b0, 1'b0);
    push("stall_ex", EX, 24'h601408, 1'b1, 1'b0);
    cycles(4);
    mem_ready = 1'b1;
    cycles(3);
`else
    exec_instr("or", 8'h0D, 24'h601408);
`endif

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_W, default 8: instruction opcode width; values 4..8.
REQ-002 SHALL have parameter ADDR_BYTES, default 2: number of operand address bytes fetched per memory/jump instruction; values 1..4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port opcode  input  OPCODE_W  current IR contents.
REQ-006 SHALL have port z_flag  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current READ or WRITE cycle.
REQ-008 SHALL have port ctrl_word  output  24  control word, decoded combinationally from state.
REQ-009 SHALL have port state  output  4  current sequencer state encoding.
REQ-010 SHALL have port instr_done  output  1  high in the final cycle of each instruction.
REQ-011 SHALL have port illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-012 ctrl_word bit map SHALL be:
- [23:20] ALU op
- 19 RLOAD, 18 TRLOAD, 17 ARLOAD, 16 ARINC, 15 PCLOAD, 14 PCINC, 13 DRLOAD, 12 ACLOAD, 11 IRLOAD, 10 ZLOAD
- 9 MEMBUS, 8 BUSMEM, 7 PCBUS, 6 DRHBUS, 5 DRLBUS, 4 TRBUS, 3 RBUS, 2 ACBUS
- 1 READ, 0 WRITE
REQ-013 Opcodes SHALL be NOP=0, LDAC=1, STAC=2, MVAC=3, MOVR=4, JUMP=5, JMPZ=6, JPNZ=7, ADD=8, SUB=9, INAC=A, CLAC=B, AND=C, OR=D, XOR=E, NOT=F; any other value (including nonzero bits above bit 3) is illegal.
REQ-014 Fetch states SHALL assert, in order:
- F1: PCBUS, ARLOAD
- F2: READ, MEMBUS, DRLOAD, PCINC
- F3: IRLOAD, PCBUS, ARLOAD
REQ-015 After F3, the decode SHALL branch on opcode as follows:
- NOP: returns to F1.
- illegal opcode: returns to F1 with illegal=1 for that cycle.
- ALU ops: EX state, ACLOAD plus ALU op (ADD 0001 RBUS, SUB 0010 RBUS, INAC 0011, CLAC 0100, AND 0101 RBUS, OR 0110 RBUS, XOR 0111 RBUS, NOT 1000), ZLOAD=1, then F1.
REQ-016 MVAC SHALL assert ACBUS, RLOAD; MOVR SHALL assert RBUS, ACLOAD, ALU op 0000; each SHALL take one execute cycle.
REQ-017 LDAC, STAC, JUMP, JMPZ and JPNZ SHALL fetch ADDR_BYTES operand bytes:
- OPRD (READ, MEMBUS, DRLOAD, PCINC, ARINC) followed by OPLD (TRLOAD), repeated ADDR_BYTES-1 times, counted by an internal byte counter.
- Then OPRD_LAST (READ, MEMBUS, DRLOAD, PCINC).
REQ-018 The final address state SHALL be as follows:
- LDAC/STAC: ADDR state asserts DRHBUS, ARLOAD, and TRBUS if ADDR_BYTES>1.
- JUMP, or JMPZ with z_flag=1, or JPNZ with z_flag=0: JMP state asserts DRHBUS, PCLOAD, and TRBUS if ADDR_BYTES>1.
- Untaken conditional jump: one idle cycle with ctrl_word=0.
REQ-019 After ADDR, LDAC SHALL run LD1 (READ, MEMBUS, DRLOAD) then LD2 (DRLBUS, ACLOAD, ALU 0000).
REQ-020 After ADDR, STAC SHALL run ST1 (ACBUS, DRLOAD) then ST2 (DRLBUS, BUSMEM, WRITE).
REQ-021 Latency SHALL be:
- 3 cycles for NOP/illegal.
- 4 cycles for ALU, MVAC, MOVR.
- 2*ADDR_BYTES+3 cycles for jumps.
- 2*ADDR_BYTES+5 cycles for LDAC/STAC.
These counts exclude stall cycles.
REQ-022 instr_done SHALL be high exactly in the last cycle before returning to F1.
REQ-023 z_flag SHALL be sampled combinationally in the OPRD_LAST cycle to select JMP or idle.

Reset
REQ-024 On rst=1, the sequencer SHALL immediately enter F1, with byte counter=0, instr_done=0, illegal=0 and ctrl_word=PCBUS|ARLOAD.
REQ-025 Reset asserted mid-instruction SHALL abort the instruction with no further ctrl bits issued.

Configuration
REQ-026 With macro SEQ_MEM_STALL_EN defined, any state asserting READ or WRITE SHALL hold while mem_ready=0.
- During the hold, all LOAD, INC and IRLOAD bits SHALL be forced to 0, while READ, WRITE and bus bits remain asserted.
- The full word SHALL be issued in the cycle mem_ready=1, after which the sequencer advances.
REQ-027 Without SEQ_MEM_STALL_EN, mem_ready SHALL be ignored and every state SHALL last one cycle.

Verification
REQ-028 Reset, then opcode=08 (ADD) -> F1, F2, F3, EX with ctrl_word=0x1_01_408 (ALU 0001, ACLOAD, ZLOAD, RBUS); instr_done in cycle 4.
REQ-029 ADDR_BYTES=2, opcode=01 (LDAC) -> 9-cycle sequence; TRLOAD only in cycle 5; ACLOAD|DRLBUS in cycle 9.
REQ-030 opcode=06 (JMPZ) with z_flag=0 -> idle cycle 7 and no PCLOAD; with z_flag=1 -> cycle 7 asserts PCLOAD|DRHBUS|TRBUS.
REQ-031 opcode=0x3F with OPCODE_W=8 -> illegal pulse in cycle 3, then F1.
REQ-032 SEQ_MEM_STALL_EN defined, mem_ready low 3 cycles in F2 -> F2 held 4 cycles; PCINC/DRLOAD high only in the 4th cycle.
REQ-033 rst asserted during LDAC LD1 -> ctrl_word = PCBUS|ARLOAD in the same cycle; next instruction is fetched normally.
